// File: rtl/brcmp_pkg.sv
// brcmp_pkg: shared modes, FSM states and the flag-to-result decision for branch_compare_seq
package brcmp_pkg;
   typedef enum logic [2:0] {EQ, NE, LT, LTU, LTZ, GEZ, LEZ, GTZ} cmp_mode_e;
   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;
   // Signed modes get their MSBs flipped at latch so one unsigned scan serves all
   function automatic logic is_signed(input cmp_mode_e mode);
      return mode inside {LT, LTZ, GEZ, LEZ, GTZ};
   endfunction
   function automatic logic decide(input cmp_mode_e mode, input logic diff, input logic lt);
      logic t;
      case (mode)
         EQ:      t = !diff;
         NE:      t = diff;
         GEZ:     t = !lt;
         LEZ:     t = lt | !diff;
         GTZ:     t = diff & !lt;
         default: t = lt;
      endcase
      return t;
   endfunction
endpackage

// File: rtl/branch_compare_slice.sv
// slice_compare: combinational unsigned CHUNK-bit comparator feeding the MSB-first scan
module slice_compare #(
   parameter int W = 8
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   output logic         neq_o,
   output logic         lt_o
);
   assign neq_o = a_i != b_i;
   assign lt_o  = a_i < b_i;
endmodule

// File: rtl/branch_compare_seq.sv
// branch_compare_seq: multi-cycle MSB-first branch comparator, one CHUNK slice per cycle.
// Define BRCMP_EARLY_EXIT_EN to finish the scan at the first differing slice.
module branch_compare_seq
   import brcmp_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic [2:0]       mode_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             flush_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             taken_o
);
   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [WIDTH-1:0] MSB = WIDTH'(1) << (WIDTH - 1);

   if (WIDTH % CHUNK != 0) begin : g_bad_chunk
      $error("WIDTH must be a multiple of CHUNK");
   end

   state_e           state_q, state_d;
   cmp_mode_e        mode_q, mode_d;
   logic [CW-1:0]    idx_q, idx_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic             diff_q, diff_d, lt_q, lt_d, done_q, done_d, taken_q, taken_d;
   logic             s_neq, s_lt, sgn;

   slice_compare #(.W(CHUNK)) u_slice (
      .a_i   (a_q[int'(idx_q)*CHUNK +: CHUNK]),
      .b_i   (b_q[int'(idx_q)*CHUNK +: CHUNK]),
      .neq_o (s_neq),
      .lt_o  (s_lt)
   );

   assign sgn = is_signed(cmp_mode_e'(mode_i));

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      idx_d   = idx_q;
      a_d     = a_q;
      b_d     = b_q;
      diff_d  = diff_q;
      lt_d    = lt_q;
      done_d  = 1'b0;
      taken_d = taken_q;
      if (flush_i && state_q != IDLE) state_d = IDLE;
      else case (state_q)
         IDLE: if (start_i && !flush_i && !done_q) begin
            state_d = SCAN;
            mode_d  = cmp_mode_e'(mode_i);
            idx_d   = CW'(NCHUNK - 1);
            a_d     = a_i ^ (sgn ? MSB : '0);
            b_d     = (mode_i[2] ? '0 : b_i) ^ (sgn ? MSB : '0);
            diff_d  = 1'b0;
            lt_d    = 1'b0;
         end
         SCAN: begin
            if (!diff_q && s_neq) begin
               diff_d = 1'b1;
               lt_d   = s_lt;
            end
`ifdef BRCMP_EARLY_EXIT_EN
            if (idx_q == '0 || (!diff_q && s_neq)) state_d = DONE;
            else idx_d = idx_q - 1'b1;
`else
            if (idx_q == '0) state_d = DONE;
            else idx_d = idx_q - 1'b1;
`endif
         end
         DONE: begin
            done_d  = 1'b1;
            taken_d = decide(mode_q, diff_q, lt_q);
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         mode_q  <= EQ;
         idx_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         diff_q  <= 1'b0;
         lt_q    <= 1'b0;
         done_q  <= 1'b0;
         taken_q <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         idx_q   <= idx_d;
         a_q     <= a_d;
         b_q     <= b_d;
         diff_q  <= diff_d;
         lt_q    <= lt_d;
         done_q  <= done_d;
         taken_q <= taken_d;
      end
   end

   assign busy_o  = state_q != IDLE;
   assign done_o  = done_q;
   assign taken_o = taken_q;
endmodule

// File: tb/tb_branch_compare_seq.sv
// tb_branch_compare_seq: directed vectors against an arithmetic reference model of branch_compare_seq
module tb_branch_compare_seq;
   localparam int WIDTH = 32;
   localparam int CHUNK = 8;
   localparam int NCHUNK = WIDTH / CHUNK;

   logic clk = 0, rst_n = 0, start_i = 0, flush_i = 0;
   logic [2:0] mode_i = 0;
   logic [WIDTH-1:0] a_i = 0, b_i = 0;
   logic busy_o, done_o, taken_o;

   int n_vec = 0, n_err = 0;

   branch_compare_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
      .clk(clk), .rst_n(rst_n), .start_i(start_i), .mode_i(mode_i),
      .a_i(a_i), .b_i(b_i), .flush_i(flush_i),
      .busy_o(busy_o), .done_o(done_o), .taken_o(taken_o)
   );

   always #5 clk = ~clk;

   function automatic logic ref_taken(input logic [2:0] m, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      logic signed [WIDTH-1:0] sa, sb;
      sa = a;
      sb = b;
      case (m)
         3'd0:    return a == b;
         3'd1:    return a != b;
         3'd2:    return sa < sb;
         3'd3:    return a < b;
         3'd4:    return sa < 0;
         3'd5:    return sa >= 0;
         3'd6:    return sa <= 0;
         default: return sa > 0;
      endcase
   endfunction

   // Model: a request occupies the unit for NCHUNK+1 edges, then pulses done with the arithmetic result
   int m_cnt = 0;
   logic m_done = 0, m_taken = 0, m_done_prev;
   logic [2:0] m_mode;
   logic [WIDTH-1:0] m_a, m_b;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_cnt = 0; m_done = 0; m_taken = 0;
      end else begin
         m_done_prev = m_done;
         m_done = 0;
         if (m_cnt > 0) begin
            if (flush_i) m_cnt = 0;
            else begin
               m_cnt--;
               if (m_cnt == 0) begin
                  m_done = 1;
                  m_taken = ref_taken(m_mode, m_a, m_b);
               end
            end
         end else if (start_i && !flush_i && !m_done_prev) begin
            m_cnt = NCHUNK + 1;
            m_mode = mode_i; m_a = a_i; m_b = b_i;
         end
      end
   end

   task automatic chk(input string name, input logic act, input logic exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      #1;
      if (rst_n) begin
         chk("busy_model", busy_o, m_cnt > 0);
         chk("done_model", done_o, m_done);
         chk("taken_model", taken_o, m_taken);
      end
   end

   task automatic run(input logic [2:0] m, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic exp, input string name);
      int cyc;
      @(negedge clk);
      start_i = 1; mode_i = m; a_i = a; b_i = b;
      @(negedge clk);
      start_i = 0;
      cyc = 0;
      while (!done_o && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      n_vec++;
      if (cyc != NCHUNK + 1) begin
         n_err++;
         $display("FAIL %s_latency: got %0d expected %0d", name, cyc, NCHUNK + 1);
      end
      chk(name, taken_o, exp);
   endtask

   logic prev;

   initial begin
      #12;
      chk("reset_busy", busy_o, 1'b0);
      chk("reset_done", done_o, 1'b0);
      chk("reset_taken", taken_o, 1'b0);
      @(negedge clk);
      rst_n = 1;
      run(3'd0, 32'h0000_07FF, 32'h0, 1'b0, "eq_7ff_0");
      run(3'd0, 32'd2, 32'd2, 1'b1, "eq_2_2");
      run(3'd1, 32'd2, 32'd2, 1'b0, "ne_2_2");
      run(3'd2, 32'hFFFF_FFFF, 32'd1, 1'b1, "lt_m1_1");
      run(3'd3, 32'hFFFF_FFFF, 32'd1, 1'b0, "ltu_m1_1");
      run(3'd2, 32'h1234_5670, 32'h1234_5678, 1'b1, "lt_low_slice");
      run(3'd4, 32'h0, 32'h1234, 1'b0, "ltz_0");
      run(3'd5, 32'h0, 32'h1234, 1'b1, "gez_0");
      run(3'd6, 32'h0, 32'h1234, 1'b1, "lez_0");
      run(3'd7, 32'h0, 32'h1234, 1'b0, "gtz_0");
      run(3'd4, 32'h8000_0000, 32'h1234, 1'b1, "ltz_min");
      run(3'd7, 32'h8000_0000, 32'h1234, 1'b0, "gtz_min");
      run(3'd5, 32'h8000_0000, 32'h0, 1'b0, "gez_min");
      run(3'd7, 32'd5, 32'hFFFF_FFFF, 1'b1, "gtz_5");
      run(3'd6, 32'd5, 32'h0, 1'b0, "lez_5");
      // start during the done pulse must be dropped
      start_i = 1; mode_i = 3'd0; a_i = 0; b_i = 0;
      @(negedge clk);
      start_i = 0;
      chk("start_in_done_ignored", busy_o, 1'b0);
      // flush mid-scan with an ignored start in between
      prev = taken_o;
      @(negedge clk);
      start_i = 1; mode_i = 3'd0; a_i = 5; b_i = 5;
      @(negedge clk);
      start_i = 0;
      @(negedge clk);
      start_i = 1; mode_i = 3'd3; a_i = 0; b_i = 1;
      @(negedge clk);
      start_i = 0; flush_i = 1;
      @(negedge clk);
      flush_i = 0;
      chk("flush_busy", busy_o, 1'b0);
      chk("flush_done", done_o, 1'b0);
      chk("flush_taken", taken_o, prev);
      repeat (6) @(negedge clk);
      run(3'd3, 32'd0, 32'd1, 1'b1, "ltu_after_flush");
      // async reset mid-scan
      @(negedge clk);
      start_i = 1; mode_i = 3'd1; a_i = 1; b_i = 2;
      @(negedge clk);
      start_i = 0;
      @(negedge clk);
      #2 rst_n = 0;
      #1;
      chk("arst_busy", busy_o, 1'b0);
      chk("arst_done", done_o, 1'b0);
      chk("arst_taken", taken_o, 1'b0);
      @(negedge clk);
      rst_n = 1;
      run(3'd0, 32'h0, 32'h0, 1'b1, "eq_0_0_after_reset");
      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
